instr_fetch: RTL

//  Fetch stage directly upstream of instr_decode. Keeps the PC, issues word requests on a req/gnt/rvalid

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 122 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_pkg
// Brief  : shared types and constants for the instruction fetch stage
// Rev    : 1.0  initial release
// ============================================================================
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      F_BOOT = 2'd0,
      F_RUN  = 2'd1,
      F_HALT = 2'd2
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_if
// Brief  : control, imem req/gnt/rvalid port and decode handshake of fetch
// Rev    : 1.0  initial release
// ============================================================================
interface instr_fetch_if #(
   parameter int XLEN = 32
);
   logic            fetch_en_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;
   logic            fetch_instr_valid_o;
   logic [XLEN-1:0] fetch_pc_r_o;
   logic [XLEN-1:0] fetch_instr_o;
   logic            fetch_instr_ready_i;

   modport master (
      input  fetch_en_i, redirect_i, redirect_pc_i,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, fetch_instr_ready_i,
      output imem_req_o, imem_addr_o,
      output fetch_instr_valid_o, fetch_pc_r_o, fetch_instr_o
   );

   modport slave (
      output fetch_en_i, redirect_i, redirect_pc_i,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, fetch_instr_ready_i,
      input  imem_req_o, imem_addr_o,
      input  fetch_instr_valid_o, fetch_pc_r_o, fetch_instr_o
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_fifo
// Brief  : in-order {pc,instr} buffer between fetch and decode, with flush
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [WIDTH-1:0]           i_wdata,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_pop;

   assign w_pop = i_pop & (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
   end

   // Head is zeroed while empty so decode never sees stale words.
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == c_FULL_CNT);
   assign o_count = r_count;
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : PC, imem request/response tracking and redirect flush for fetch
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR  = '0,
   parameter int              FIFO_DEPTH = 2,
   parameter int              MAX_OUTST  = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   instr_fetch_if.master      bus
);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = ((OW > CW) ? OW : CW) + 1;
   localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic [OW-1:0]   r_outst;
   logic [OW-1:0]   r_discard;
   logic [XLEN-1:0] r_tag [MAX_OUTST];
   logic [TW-1:0]   r_tag_wptr;
   logic [TW-1:0]   r_tag_rptr;

   logic            w_req;
   logic            w_accept;
   logic            w_drop;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic [CW-1:0]   w_fifo_count;
   logic [SW-1:0]   w_used;

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   // A head popping this cycle frees its slot for a new request.
   assign w_pop    = ~w_fifo_empty & bus.fetch_instr_ready_i & ~bus.redirect_i;
   assign w_used   = SW'(r_outst) + SW'(w_fifo_count) - SW'(w_pop);
   assign w_req    = (r_state == F_RUN) & ~bus.redirect_i
                   & (w_used < SW'(FIFO_DEPTH))
                   & (r_outst < OW'(MAX_OUTST));
   assign w_accept = w_req & bus.imem_gnt_i;
   assign w_drop   = bus.imem_rvalid_i & (r_discard != '0);
   assign w_push   = bus.imem_rvalid_i & ~w_drop & ~bus.redirect_i;

   assign bus.imem_req_o          = w_req;
   assign bus.imem_addr_o         = r_pc;
   assign bus.fetch_instr_valid_o = ~w_fifo_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= F_BOOT;
         r_pc       <= BOOT_ADDR;
         r_outst    <= '0;
         r_discard  <= '0;
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else begin
         case (r_state)
            F_BOOT:  r_state <= F_RUN;
            F_RUN:   if (!bus.fetch_en_i && !bus.redirect_i) r_state <= F_HALT;
            F_HALT:  if (bus.fetch_en_i || bus.redirect_i) r_state <= F_RUN;
            default: r_state <= F_BOOT;
         endcase

         if (bus.redirect_i)
            r_pc <= bus.redirect_pc_i & ~XLEN'(3);
         else if (w_accept)
            r_pc <= r_pc + XLEN'(INSTR_BYTES);

         case ({w_accept, bus.imem_rvalid_i})
            2'b10:   r_outst <= r_outst + 1'b1;
            2'b01:   r_outst <= r_outst - 1'b1;
            default: r_outst <= r_outst;
         endcase

         // Everything still in flight at a redirect belongs to the old path.
         if (bus.redirect_i)
            r_discard <= r_outst - OW'(bus.imem_rvalid_i);
         else if (w_drop)
            r_discard <= r_discard - 1'b1;

         if (w_accept)          r_tag_wptr <= tag_next(r_tag_wptr);
         if (bus.imem_rvalid_i) r_tag_rptr <= tag_next(r_tag_rptr);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) r_tag[r_tag_wptr] <= r_pc;
   end

   instr_fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_i),
      .i_wdata ({r_tag[r_tag_rptr], bus.imem_rdata_i}),
      .o_rdata ({bus.fetch_pc_r_o, bus.fetch_instr_o}),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_push && w_fifo_full));

endmodule
`default_nettype wire
